// File: rtl/jam_pkg.sv
// jam_pkg
// Shared definitions for the job-assignment (JAM) datapath. The cost loader
// uses it now, and the assignment engine will import the same package later
// so both sides agree on matrix size and cost width.
//   N       : workers = jobs (power of two)
//   COST_W  : bits per cost entry
//   IDX_W   : width of a worker/job index
//   NN      : number of entries in one matrix (N*N)
//   CNT_W   : width of the beat counter
//   LB_W    : width of the lower-bound sum (N costs added together)
package jam_pkg;

    localparam int N      = 8;
    localparam int COST_W = 7;
    localparam int IDX_W  = $clog2(N);
    localparam int NN     = N * N;
    localparam int CNT_W  = IDX_W * 2 + 1;
    localparam int LB_W   = IDX_W + COST_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_e;

    function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_row_min.sv
// jam_row_min
// Tracks the minimum of the row currently being loaded and adds it to a
// running accumulator when the row's last beat arrives. The final
// accumulator value is a lower bound on any assignment's total cost.
// Only compiled when LOWER_BOUND_EN is defined.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   beat_en    : an accepted, well-framed beat is present this cycle
//   clear      : drop the accumulator (matrix discarded or released)
//   col        : job index of the current beat
//   data       : cost carried by the current beat
//   acc        : sum of completed row minima
`ifdef LOWER_BOUND_EN
module jam_row_min
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              beat_en,
    input  logic              clear,
    input  logic [IDX_W-1:0]  col,
    input  logic [COST_W-1:0] data,
    output logic [LB_W-1:0]   acc
);

    logic [COST_W-1:0] row_min_q, row_min_d;
    logic [LB_W-1:0]   acc_q, acc_d;
    logic [COST_W-1:0] eff_min;

    // The first column of a row restarts the minimum, so the register
    // never needs an explicit reset between rows.
    always_comb begin
        eff_min   = (col == '0) ? data : cost_min(row_min_q, data);
        row_min_d = row_min_q;
        acc_d     = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (beat_en) begin
            row_min_d = eff_min;
            if (col == IDX_W'(N - 1)) begin
                acc_d = acc_q + LB_W'(eff_min);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_min_q <= '0;
            acc_q     <= '0;
        end else begin
            row_min_q <= row_min_d;
            acc_q     <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule
`endif

// File: rtl/jam_cost_loader.sv
// jam_cost_loader
// Upstream feeder for the JAM engine. Accepts an N x N cost matrix as a
// valid/ready stream (worker-major, job-minor), stores it, and then serves
// combinational W/J -> Cost lookups until the engine signals completion.
// Optional feature: define LOWER_BOUND_EN to add the lb_cost output
// (sum over workers of the row minimum).
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   in_valid      : upstream beat valid
//   in_ready      : loader accepts a beat (state decode only)
//   in_data       : cost entry of the current beat
//   in_last       : final beat of a matrix
//   W, J          : lookup worker / job index
//   Cost          : table[W][J] while the table is valid, else 0
//   table_valid   : table complete and frozen
//   consumer_done : engine finished with the table
//   frame_err     : sticky framing-error flag
//   lb_cost       : (LOWER_BOUND_EN only) lower bound on total cost
module jam_cost_loader
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_last,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              table_valid,
    input  logic              consumer_done,
    output logic              frame_err
`ifdef LOWER_BOUND_EN
    ,
    output logic [LB_W-1:0]   lb_cost
`endif
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [COST_W-1:0] cost_tbl_q [N][N];
    logic [COST_W-1:0] cost_tbl_d [N][N];

    logic              xfer;
    logic              last_idx;
    logic              bad_frame;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  wr_col;

    assign in_ready  = (state_q != READY);
    assign xfer      = in_valid && in_ready;
    assign last_idx  = (cnt_q == CNT_W'(NN - 1));
    // A frame is malformed when in_last and the counter disagree about
    // where the matrix ends.
    assign bad_frame = xfer && (in_last != last_idx);
    assign wr_row    = cnt_q[2*IDX_W-1:IDX_W];
    assign wr_col    = cnt_q[IDX_W-1:0];

    // Next-state logic. A bad frame consumes the beat and drops back to
    // IDLE; stale entries left in the table are harmless because Cost is
    // gated by table_valid and a full reload overwrites every entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_err_d = frame_err_q;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (bad_frame) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        frame_err_d = 1'b1;
                    end else if (last_idx) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (consumer_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Table write path: every accepted beat lands at its row/column slot.
    always_comb begin
        cost_tbl_d = cost_tbl_q;
        if (xfer) begin
            cost_tbl_d[wr_row][wr_col] = in_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    cost_tbl_q[r][c] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            cost_tbl_q  <= cost_tbl_d;
        end
    end

    assign table_valid = (state_q == READY);
    assign frame_err   = frame_err_q;
    assign Cost        = table_valid ? cost_tbl_q[W][J] : '0;

`ifdef LOWER_BOUND_EN
    logic            lb_beat;
    logic            lb_clear;
    logic [LB_W-1:0] lb_acc;

    // The accumulator restarts whenever a matrix is thrown away or released.
    assign lb_beat  = xfer && !bad_frame;
    assign lb_clear = bad_frame || ((state_q == READY) && consumer_done);

    jam_row_min u_row_min (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .beat_en (lb_beat),
        .clear   (lb_clear),
        .col     (wr_col),
        .data    (in_data),
        .acc     (lb_acc)
    );

    assign lb_cost = table_valid ? lb_acc : '0;
`endif

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader
// Scoreboard bench for jam_cost_loader. Stimulus pushes expectations into a
// queue and raises a check request; a monitor on the falling edge pops and
// compares against the live DUT outputs. Define LOWER_BOUND_EN to also
// exercise lb_cost.
module tb_jam_cost_loader;
    import jam_pkg::*;

    localparam int K_COST   = 0;
    localparam int K_TVALID = 1;
    localparam int K_READY  = 2;
    localparam int K_FERR   = 3;
    localparam int K_LB     = 4;
    localparam int K_XFER   = 5;

    typedef struct {
        string name;
        int    kind;
        int    exp;
    } chk_t;

    logic              CLK;
    logic              RST_N;
    logic              in_valid;
    logic              in_ready;
    logic [COST_W-1:0] in_data;
    logic              in_last;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;
    logic              table_valid;
    logic              consumer_done;
    logic              frame_err;
    logic [LB_W-1:0]   lb_cost;

    chk_t sb_q[$];
    logic chk_req;
    int   n_checks;
    int   n_fail;
    int   xfer_cnt;
    int   xfer_base;

    jam_cost_loader dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .W             (W),
        .J             (J),
        .Cost          (Cost),
        .table_valid   (table_valid),
        .consumer_done (consumer_done),
        .frame_err     (frame_err)
`ifdef LOWER_BOUND_EN
        ,
        .lb_cost       (lb_cost)
`endif
    );

`ifndef LOWER_BOUND_EN
    assign lb_cost = '0;
`endif

    // Free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count handshakes as the bench sees them at each rising edge.
    always @(posedge CLK) begin
        if (in_valid && in_ready) xfer_cnt++;
    end

    // Monitor: drains every pending expectation when a check is requested.
    always @(negedge CLK) begin
        if (chk_req) begin
            while (sb_q.size() > 0) begin
                chk_t it;
                int   act;
                it = sb_q.pop_front();
                case (it.kind)
                    K_COST:   act = int'(Cost);
                    K_TVALID: act = int'(table_valid);
                    K_READY:  act = int'(in_ready);
                    K_FERR:   act = int'(frame_err);
                    K_LB:     act = int'(lb_cost);
                    default:  act = xfer_cnt;
                endcase
                n_checks++;
                if (act != it.exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %0d, expected %0d", it.name, act, it.exp);
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [COST_W-1:0] patVal(input int pat, input int w, input int j);
        case (pat)
            0:       return COST_W'((8 * w + j) % 128);
            1:       return COST_W'(127);
            default: return (w == j) ? COST_W'(w + 1) : COST_W'(100);
        endcase
    endfunction

    task automatic checkOutput(input string name, input int kind, input int exp);
        chk_t it;
        it.name = name;
        it.kind = kind;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic runChecks();
        chk_req = 1'b1;
        @(negedge CLK);
        #1;
        chk_req = 1'b0;
    endtask

    task automatic checkCost(input string name, input int w, input int j, input int exp);
        W = IDX_W'(w);
        J = IDX_W'(j);
        checkOutput(name, K_COST, exp);
        runChecks();
    endtask

    // One beat: hold valid until it transfers, bounded by a cycle budget.
    task automatic applyStimulus(input logic [COST_W-1:0] d, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL beat_timeout: in_ready got 0, expected 1");
        end else begin
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Stream n_beats of a pattern; last_at picks the beat carrying in_last
    // (-1 for none), done_at raises consumer_done alongside one beat.
    task automatic loadMatrix(input int pat, input bit stall, input int n_beats,
                              input int last_at, input int done_at);
        for (int i = 0; i < n_beats; i++) begin
            consumer_done = (i == done_at);
            applyStimulus(patVal(pat, i / N, i % N), (i == last_at));
            consumer_done = 1'b0;
            if (stall) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic pulseDone();
        consumer_done = 1'b1;
        @(posedge CLK);
        #1;
        consumer_done = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        chk_req       = 1'b0;
        n_checks      = 0;
        n_fail        = 0;
        xfer_cnt      = 0;
        RST_N         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        W             = '0;
        J             = '0;
        consumer_done = 1'b0;
        #2;

        $display("[TB] reset state");
        checkOutput("rst_in_ready", K_READY, 1);
        checkOutput("rst_table_valid", K_TVALID, 0);
        checkOutput("rst_frame_err", K_FERR, 0);
        checkOutput("rst_cost", K_COST, 0);
        checkOutput("rst_lb", K_LB, 0);
        runChecks();
        RST_N = 1'b1;

        $display("[TB] ramp load");
        loadMatrix(0, 1'b0, NN, NN - 1, -1);
        checkOutput("ramp_table_valid", K_TVALID, 1);
        checkOutput("ramp_in_ready", K_READY, 0);
`ifdef LOWER_BOUND_EN
        checkOutput("ramp_lb", K_LB, 224);
`endif
        runChecks();
        checkCost("ramp_cost_3_5", 3, 5, 29);
        checkCost("ramp_cost_7_7", 7, 7, 63);

        $display("[TB] release and stalled ramp load");
        pulseDone();
        checkOutput("rel_table_valid", K_TVALID, 0);
        checkOutput("rel_in_ready", K_READY, 1);
        runChecks();
        xfer_base = xfer_cnt;
        loadMatrix(0, 1'b1, NN, NN - 1, -1);
        checkOutput("stall_xfers", K_XFER, xfer_base + NN);
        checkOutput("stall_table_valid", K_TVALID, 1);
        runChecks();
        checkCost("stall_cost_2_6", 2, 6, 22);
        checkCost("stall_cost_7_0", 7, 0, 56);

        $display("[TB] done with simultaneous beat, reload 127s");
        xfer_base     = xfer_cnt;
        consumer_done = 1'b1;
        in_valid      = 1'b1;
        in_data       = COST_W'(127);
        in_last       = 1'b0;
        @(posedge CLK);
        #1;
        consumer_done = 1'b0;
        checkOutput("sim_no_xfer", K_XFER, xfer_base);
        checkOutput("sim_table_valid", K_TVALID, 0);
        checkOutput("sim_in_ready", K_READY, 1);
        runChecks();
        loadMatrix(1, 1'b0, NN, NN - 1, -1);
        checkOutput("max_xfers", K_XFER, xfer_base + NN);
        checkOutput("max_table_valid", K_TVALID, 1);
`ifdef LOWER_BOUND_EN
        checkOutput("max_lb", K_LB, 1016);
`endif
        runChecks();
        checkCost("max_cost_0_0", 0, 0, 127);
        checkCost("max_cost_5_2", 5, 2, 127);

        $display("[TB] early in_last framing error");
        pulseDone();
        loadMatrix(0, 1'b0, 11, 10, -1);
        checkOutput("early_frame_err", K_FERR, 1);
        checkOutput("early_table_valid", K_TVALID, 0);
        checkOutput("early_in_ready", K_READY, 1);
        runChecks();
        checkCost("early_cost_gated", 1, 2, 0);

        $display("[TB] clean load after error, done ignored mid-load");
        loadMatrix(2, 1'b0, NN, NN - 1, 20);
        checkOutput("diag_table_valid", K_TVALID, 1);
        checkOutput("diag_frame_err_sticky", K_FERR, 1);
`ifdef LOWER_BOUND_EN
        checkOutput("diag_lb", K_LB, 36);
`endif
        runChecks();
        checkCost("diag_cost_4_4", 4, 4, 5);
        checkCost("diag_cost_4_6", 4, 6, 100);

        $display("[TB] missing in_last on final beat");
        pulseDone();
        loadMatrix(0, 1'b0, NN, -1, -1);
        checkOutput("nolast_table_valid", K_TVALID, 0);
        checkOutput("nolast_in_ready", K_READY, 1);
        checkOutput("nolast_frame_err", K_FERR, 1);
        runChecks();

        $display("[TB] reset in the middle of a load");
        loadMatrix(0, 1'b0, 30, -1, -1);
        RST_N = 1'b0;
        W     = IDX_W'(3);
        J     = IDX_W'(5);
        checkOutput("mid_rst_in_ready", K_READY, 1);
        checkOutput("mid_rst_table_valid", K_TVALID, 0);
        checkOutput("mid_rst_frame_err", K_FERR, 0);
        checkOutput("mid_rst_cost", K_COST, 0);
        checkOutput("mid_rst_lb", K_LB, 0);
        runChecks();
        RST_N = 1'b1;
        loadMatrix(0, 1'b0, NN, NN - 1, -1);
        checkOutput("post_rst_table_valid", K_TVALID, 1);
        checkOutput("post_rst_frame_err", K_FERR, 0);
        runChecks();
        checkCost("post_rst_cost_3_5", 3, 5, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
